fetch_stage: RTL and testbench

Instruction-fetch stage for the multi-cycle core. It holds the program counter, drives the synchronous instruction memory, and latches the fetched word into the IF/ID pipeline register. It is driven by the stage controller's strobes: `if_id_wren` captures the fetched word, `wb_if_wren` commits the next PC, and `stage_reset_n` clears the stage. Its outputs feed the decode stage.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 72 +++++++
 tb/tb_fetch_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: controller strobes, instruction-memory port and IF/ID outputs.
// master = the fetch stage, slave = controller/memory/decode side.
interface fetch_stage_if #(
    parameter int IMEM_AW = 14
);
    logic               stage_reset_n;
    logic               if_id_wren;
    logic               wb_if_wren;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        pc;
    logic [31:0]        if_id_pc;
    logic [31:0]        if_id_instr;
    logic               if_id_valid;
    logic               halted;
    logic [31:0]        fault_pc;
    logic [31:0]        instret;

    modport master (
        input  stage_reset_n, if_id_wren, wb_if_wren, branch_taken, branch_target, imem_rdata,
        output imem_addr, pc, if_id_pc, if_id_instr, if_id_valid, halted, fault_pc, instret
    );

    modport slave (
        output stage_reset_n, if_id_wren, wb_if_wren, branch_taken, branch_target, imem_rdata,
        input  imem_addr, pc, if_id_pc, if_id_instr, if_id_valid, halted, fault_pc, instret
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous IMEM address, IF/ID register
// and a sticky fault latch for misaligned or out-of-range fetch targets.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master bus
);
    localparam logic [31:0] NOP        = 32'h0000_0013;
    // Bits above the reachable byte range; any set bit means the target is unmapped.
    localparam logic [31:0] RANGE_MASK = ~((32'h1 << (IMEM_AW + 2)) - 32'h1);

    logic [31:0] pc_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_instr_q;
    logic        if_id_valid_q;
    logic        halted_q;
    logic [31:0] fault_pc_q;
    logic [31:0] instret_q;

    logic [31:0] candidate;
    logic        cand_fault;

    always_comb begin
        candidate  = bus.branch_taken ? bus.branch_target : pc_q + 32'd4;
        cand_fault = (candidate[1:0] != 2'b00) || ((candidate & RANGE_MASK) != 32'h0);
    end

    // NOTE: reset_n is sampled only on clk (synchronous), so it is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_pc_q    <= 32'h0;
            instret_q     <= 32'h0;
        end else if (!bus.stage_reset_n) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let a same-cycle capture see the pre-commit pc_q.
            if (bus.if_id_wren) begin
                if_id_instr_q <= bus.imem_rdata;
                if_id_pc_q    <= pc_q;
                if_id_valid_q <= !halted_q;
            end
            if (bus.wb_if_wren && !halted_q) begin
                if (cand_fault) begin
                    halted_q   <= 1'b1;
                    fault_pc_q <= candidate;
                end else begin
                    pc_q      <= candidate;
                    instret_q <= instret_q + 32'd1;
                end
            end
        end
    end

    assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
    assign bus.pc          = pc_q;
    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.halted      = halted_q;
    assign bus.fault_pc    = fault_pc_q;
    assign bus.instret     = instret_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, then random
// stimulus compared against a behavioural model with its own memory view.
module tb_fetch_stage;
    localparam int          AW    = 14;
    localparam int          WORDS = 1 << AW;
    localparam longint      LIMIT = longint'(1) << (AW + 2);

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fetch_stage_if #(.IMEM_AW(AW)) bus ();
    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [31:0] mem [0:WORDS-1];
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model state (what each output should hold after the last edge)
    longint m_pc, m_ifpc, m_instr, m_fpc, m_ir, m_rd;
    bit     m_valid, m_halt;

    function automatic void model_step(bit rst_n, bit srst_n, bit ifw, bit wbw, bit bt, logic [31:0] tgt);
        longint cand;
        longint old_pc = m_pc;
        longint old_rd = m_rd;
        m_rd = longint'(mem[(old_pc / 4) % WORDS]);
        if (!rst_n) begin
            m_pc = 0; m_ifpc = 0; m_instr = 'h13; m_valid = 0;
            m_halt = 0; m_fpc = 0; m_ir = 0;
        end else if (!srst_n) begin
            m_pc = 0; m_instr = 'h13; m_valid = 0;
        end else begin
            if (ifw) begin
                m_instr = old_rd; m_ifpc = old_pc; m_valid = !m_halt;
            end
            if (wbw && !m_halt) begin
                cand = bt ? longint'(tgt) : (old_pc + 4) % (longint'(1) << 32);
                if ((cand % 4) != 0 || cand >= LIMIT) begin
                    m_halt = 1; m_fpc = cand;
                end else begin
                    m_pc = cand; m_ir = (m_ir + 1) % (longint'(1) << 32);
                end
            end
        end
    endfunction

    task automatic cycle(input bit rst_n, input bit srst_n, input bit ifw, input bit wbw,
                         input bit bt, input logic [31:0] tgt);
        reset_n           = rst_n;
        bus.stage_reset_n = srst_n;
        bus.if_id_wren    = ifw;
        bus.wb_if_wren    = wbw;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        @(posedge clk);
        model_step(rst_n, srst_n, ifw, wbw, bt, tgt);
        #1;
    endtask

    typedef struct {
        bit          rst_n, srst_n, ifw, wbw, bt;
        logic [31:0] tgt;
        logic [31:0] pc, ifpc, instr;
        bit          valid, halt;
        logic [31:0] fpc, ir;
    } vec_t;

    function automatic vec_t v(bit r, bit s, bit i, bit w, bit b, logic [31:0] t,
                               logic [31:0] p, logic [31:0] ip, logic [31:0] in,
                               bit va, bit h, logic [31:0] f, logic [31:0] ir);
        vec_t x;
        x.rst_n = r; x.srst_n = s; x.ifw = i; x.wbw = w; x.bt = b; x.tgt = t;
        x.pc = p; x.ifpc = ip; x.instr = in; x.valid = va; x.halt = h; x.fpc = f; x.ir = ir;
        return x;
    endfunction

    vec_t tbl [27];

    initial begin
        for (int k = 0; k < WORDS; k++) mem[k] = 32'h1000 + k;

        //            rst s  if wb bt tgt         pc       ifpc  instr    v  h  fault     ir
        tbl[0]  = v(0, 1, 0, 0, 0, 0,          0,       0,    'h13,    0, 0, 0,        0);
        tbl[1]  = v(0, 1, 0, 0, 0, 0,          0,       0,    'h13,    0, 0, 0,        0);
        tbl[2]  = v(1, 0, 0, 0, 0, 0,          0,       0,    'h13,    0, 0, 0,        0);
        tbl[3]  = v(1, 1, 0, 0, 0, 0,          0,       0,    'h13,    0, 0, 0,        0);
        tbl[4]  = v(1, 1, 1, 0, 0, 0,          0,       0,    'h1000,  1, 0, 0,        0);
        tbl[5]  = v(1, 1, 0, 0, 0, 0,          0,       0,    'h1000,  1, 0, 0,        0);
        tbl[6]  = v(1, 1, 0, 1, 0, 0,          4,       0,    'h1000,  1, 0, 0,        1);
        tbl[7]  = v(1, 1, 0, 0, 0, 0,          4,       0,    'h1000,  1, 0, 0,        1);
        tbl[8]  = v(1, 1, 1, 0, 0, 0,          4,       4,    'h1001,  1, 0, 0,        1);
        tbl[9]  = v(1, 1, 0, 0, 0, 0,          4,       4,    'h1001,  1, 0, 0,        1);
        tbl[10] = v(1, 1, 0, 1, 0, 0,          8,       4,    'h1001,  1, 0, 0,        2);
        tbl[11] = v(1, 1, 0, 0, 0, 0,          8,       4,    'h1001,  1, 0, 0,        2);
        tbl[12] = v(1, 1, 1, 0, 0, 0,          8,       8,    'h1002,  1, 0, 0,        2);
        tbl[13] = v(1, 1, 0, 0, 0, 0,          8,       8,    'h1002,  1, 0, 0,        2);
        tbl[14] = v(1, 1, 0, 1, 0, 0,          'hC,     8,    'h1002,  1, 0, 0,        3);
        tbl[15] = v(1, 1, 0, 1, 1, 'h40,       'h40,    8,    'h1002,  1, 0, 0,        4);
        tbl[16] = v(1, 1, 0, 0, 0, 0,          'h40,    8,    'h1002,  1, 0, 0,        4);
        tbl[17] = v(1, 1, 1, 0, 0, 0,          'h40,    'h40, 'h1010,  1, 0, 0,        4);
        tbl[18] = v(1, 1, 0, 1, 1, 'h42,       'h40,    'h40, 'h1010,  1, 1, 'h42,     4);
        tbl[19] = v(1, 1, 0, 1, 0, 0,          'h40,    'h40, 'h1010,  1, 1, 'h42,     4);
        tbl[20] = v(1, 1, 1, 0, 0, 0,          'h40,    'h40, 'h1010,  0, 1, 'h42,     4);
        tbl[21] = v(1, 0, 1, 1, 0, 0,          0,       'h40, 'h13,    0, 1, 'h42,     4);
        tbl[22] = v(1, 1, 1, 0, 0, 0,          0,       0,    'h1010,  0, 1, 'h42,     4);
        tbl[23] = v(0, 1, 1, 1, 0, 0,          0,       0,    'h13,    0, 0, 0,        0);
        tbl[24] = v(1, 1, 0, 1, 1, 'hFFFC,     'hFFFC,  0,    'h13,    0, 0, 0,        1);
        tbl[25] = v(1, 1, 0, 1, 0, 0,          'hFFFC,  0,    'h13,    0, 1, 'h10000,  1);
        tbl[26] = v(0, 1, 0, 0, 0, 0,          0,       0,    'h13,    0, 0, 0,        0);

        m_pc = 0; m_ifpc = 0; m_instr = 'h13; m_fpc = 0; m_ir = 0; m_rd = 0;
        m_valid = 0; m_halt = 0;

        foreach (tbl[i]) begin
            cycle(tbl[i].rst_n, tbl[i].srst_n, tbl[i].ifw, tbl[i].wbw, tbl[i].bt, tbl[i].tgt);
            check($sformatf("vec%0d pc", i),       bus.pc,                 tbl[i].pc);
            check($sformatf("vec%0d if_id_pc", i), bus.if_id_pc,           tbl[i].ifpc);
            check($sformatf("vec%0d instr", i),    bus.if_id_instr,        tbl[i].instr);
            check($sformatf("vec%0d valid", i),    32'(bus.if_id_valid),   32'(tbl[i].valid));
            check($sformatf("vec%0d halted", i),   32'(bus.halted),        32'(tbl[i].halt));
            check($sformatf("vec%0d fault_pc", i), bus.fault_pc,           tbl[i].fpc);
            check($sformatf("vec%0d instret", i),  bus.instret,            tbl[i].ir);
        end

        // Randomised phase against the behavioural model
        for (int n = 0; n < 3000; n++) begin
            bit          r, s, i, w, b;
            logic [31:0] t;
            int          sel;
            r = ($urandom_range(0, 63) != 0);
            s = ($urandom_range(0, 31) != 0);
            i = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 19);
            if (sel < 14)      t = 32'($urandom_range(0, WORDS - 1)) << 2;
            else if (sel < 17) t = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
            else               t = $urandom;
            cycle(r, s, i, w, b, t);
            check("rnd imem_addr", 32'(bus.imem_addr), 32'((m_pc / 4) % WORDS));
            check("rnd pc",        bus.pc,                32'(m_pc));
            check("rnd if_id_pc",  bus.if_id_pc,          32'(m_ifpc));
            check("rnd instr",     bus.if_id_instr,       32'(m_instr));
            check("rnd valid",     32'(bus.if_id_valid),  32'(m_valid));
            check("rnd halted",    32'(bus.halted),       32'(m_halt));
            check("rnd fault_pc",  bus.fault_pc,          32'(m_fpc));
            check("rnd instret",   bus.instret,           32'(m_ir));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
